// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage: single-cycle multiply,
// 32-step restoring divide, and MTHI/MTLO writes into architectural HI/LO.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        whi,
    input  logic        wlo,
    input  logic [31:0] wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        ex_stall_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic        launch;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] quo, rem, dvsr;
    logic [4:0]  cnt;

    assign launch = (state == IDLE) && start && !flush;

    // Signed ops (op[0]==0) work on magnitudes; signs are reapplied at the end.
    function automatic logic [31:0] mag(input logic [31:0] x, input logic is_unsigned);
        return (!is_unsigned && x[31]) ? (32'd0 - x) : x;
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = op[1] ? DIV : MUL;
            MUL:  state_nxt = flush ? IDLE : DONE;
            DIV:  if (flush) state_nxt = IDLE;
                  else if (cnt == 5'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ex_stall_o = !flush && (launch || state == MUL || state == DIV);
    end

    // ---------------- datapath ----------------
    logic [63:0] ext_a, ext_b, prod;
    logic [32:0] trial, sub;
    logic        fits;
    logic [31:0] rem_step, quo_step, q_fix, r_fix;

    always_comb begin
        ext_a = op_r[0] ? {32'd0, a_r} : {{32{a_r[31]}}, a_r};
        ext_b = op_r[0] ? {32'd0, b_r} : {{32{b_r[31]}}, b_r};
        prod  = ext_a * ext_b;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial    = {rem, quo[31]};
        sub      = trial - {1'b0, dvsr};
        fits     = trial >= {1'b0, dvsr};
        rem_step = fits ? sub[31:0] : trial[31:0];
        quo_step = {quo[30:0], fits};
        q_fix    = (!op_r[0] && (a_r[31] ^ b_r[31])) ? (32'd0 - quo_step) : quo_step;
        r_fix    = (!op_r[0] && a_r[31]) ? (32'd0 - rem_step) : rem_step;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
            cnt  <= 5'd0;
        end else begin
            if (launch) begin
                op_r <= op;
                a_r  <= a;
                b_r  <= b;
                quo  <= mag(a, op[0]);
                dvsr <= mag(b, op[0]);
                rem  <= 32'd0;
                cnt  <= 5'd0;
            end
            case (state)
                MUL: if (!flush) {hi_o, lo_o} <= prod;
                DIV: if (!flush) begin
                    quo <= quo_step;
                    rem <= rem_step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // Zero divisor gives all-ones quotient and the dividend back.
                        if (b_r == 32'd0) begin
                            hi_o <= a_r;
                            lo_o <= 32'hFFFF_FFFF;
                        end else begin
                            hi_o <= r_fix;
                            lo_o <= q_fix;
                        end
                    end
                end
                default: begin
                    if (whi) hi_o <= wdata;
                    if (wlo) lo_o <= wdata;
                end
            endcase
        end
    end

endmodule
